// File: rtl/bram_sweep_reader_if.sv
// rtl/bram_sweep_reader_if.sv - block-RAM read port and tagged word stream of the sweep reader
// The master side issues RAM reads and sources words; the slave side is the RAM mux plus consumer.
interface bram_sweep_reader_if #(
  parameter int NUM_BANKS = 52,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 9
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [BANK_W-1:0] bram_bank;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_ce;
  logic [DATA_W-1:0] bram_dout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [BANK_W-1:0] out_bank;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output bram_bank, bram_addr, bram_ce,
    input  bram_dout,
    output out_valid, out_data, out_bank, out_addr,
    input  out_ready
  );

  modport slave (
    input  bram_bank, bram_addr, bram_ce,
    output bram_dout,
    input  out_valid, out_data, out_bank, out_addr,
    output out_ready
  );
endinterface

// File: rtl/bram_sweep_reader.sv
// rtl/bram_sweep_reader.sv - sweeps every block-RAM address into a tagged stream with signature
// Reads are throttled so pipeline plus FIFO occupancy never exceeds FIFO_DEPTH.
module bram_sweep_reader #(
  parameter int NUM_BANKS  = 52,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 9,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                signature,
  bram_sweep_reader_if.master        rd_if
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [BANK_W-1:0]   r_bank;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_in_flight;
  logic [CNT_W-1:0]    r_fifo_count;
  logic [RD_LAT-1:0]   r_pipe_v;
  logic [BANK_W-1:0]   r_pipe_bank [RD_LAT];
  logic [ADDR_W-1:0]   r_pipe_addr [RD_LAT];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [BANK_W-1:0]   r_fifo_bank [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [31:0]         r_signature;

  logic                w_issue;
  logic                w_last_ptr;
  logic                w_start_ok;
  logic                w_capture;
  logic                w_pop;
  logic [CNT_W-1:0]    w_occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_occupancy = r_in_flight + r_fifo_count;
  assign w_last_ptr  = (r_bank == LAST_BANK) && (r_addr == {ADDR_W{1'b1}});
  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_capture   = r_pipe_v[RD_LAT-1];
  assign w_pop       = (r_fifo_count != '0) && rd_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_issue && w_last_ptr) w_next_state = S_DRAIN;
      S_DRAIN: if (r_in_flight == '0 && r_fifo_count == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      S_RUN: begin
        busy    = 1'b1;
        w_issue = (w_occupancy < DEPTH_C);
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The pointer parks on the final address rather than wrapping past the last bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= '0;
      r_addr <= '0;
    end else if (w_start_ok) begin
      r_bank <= '0;
      r_addr <= '0;
    end else if (w_issue && !w_last_ptr) begin
      if (r_addr == {ADDR_W{1'b1}}) begin
        r_addr <= '0;
        r_bank <= r_bank + 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_bank[i] <= '0;
        r_pipe_addr[i] <= '0;
      end
    end else begin
      r_pipe_v[0]    <= w_issue;
      r_pipe_bank[0] <= r_bank;
      r_pipe_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]    <= r_pipe_v[i-1];
        r_pipe_bank[i] <= r_pipe_bank[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_flight <= '0;
    end else begin
      case ({w_issue, w_capture})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_fifo_data[r_wr_ptr] <= rd_if.bram_dout;
      r_fifo_bank[r_wr_ptr] <= r_pipe_bank[RD_LAT-1];
      r_fifo_addr[r_wr_ptr] <= r_pipe_addr[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_capture) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_capture, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_signature <= '0;
    else if (w_start_ok) r_signature <= '0;
    else if (w_pop)      r_signature <= {r_signature[30:0], r_signature[31]} ^ 32'(rd_if.out_data);
  end

  assign rd_if.bram_ce   = w_issue;
  assign rd_if.bram_bank = r_bank;
  assign rd_if.bram_addr = r_addr;
  assign rd_if.out_valid = (r_fifo_count != '0);
  assign rd_if.out_data  = r_fifo_data[r_rd_ptr];
  assign rd_if.out_bank  = r_fifo_bank[r_rd_ptr];
  assign rd_if.out_addr  = r_fifo_addr[r_rd_ptr];
  assign signature       = r_signature;
endmodule

// File: tb/tb_bram_sweep_reader.sv
// tb/tb_bram_sweep_reader.sv - directed bench for bram_sweep_reader
// A 2-bank/4-word instance covers the hand-computed cases; a 52-bank/32-word one takes random traffic.
module tb_bram_sweep_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s, start_l;
  logic        busy_s, done_s, busy_l, done_l;
  logic [31:0] sig_s, sig_l;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bram_sweep_reader_if #(.NUM_BANKS(2),  .ADDR_W(2), .DATA_W(9)) bus_s ();
  bram_sweep_reader_if #(.NUM_BANKS(52), .ADDR_W(5), .DATA_W(9)) bus_l ();

  bram_sweep_reader #(.NUM_BANKS(2), .ADDR_W(2), .DATA_W(9), .RD_LAT(2), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .signature(sig_s), .rd_if(bus_s)
  );

  bram_sweep_reader #(.NUM_BANKS(52), .ADDR_W(5), .DATA_W(9), .RD_LAT(2), .FIFO_DEPTH(4)) u_large (
    .clk(clk), .rst_n(rst_n), .start(start_l), .busy(busy_l), .done(done_l),
    .signature(sig_l), .rd_if(bus_l)
  );

  // Two-stage registered RAM models: small returns bank*4+addr, large reads a random table.
  logic [8:0] s_stage;
  logic [8:0] l_stage;
  logic [8:0] mem_l [0:52*32-1];

  always @(posedge clk) begin
    if (bus_s.bram_ce) s_stage <= 9'(int'(bus_s.bram_bank) * 4 + int'(bus_s.bram_addr));
    bus_s.bram_dout <= s_stage;
    if (bus_l.bram_ce) l_stage <= mem_l[int'(bus_l.bram_bank) * 32 + int'(bus_l.bram_addr)];
    bus_l.bram_dout <= l_stage;
  end

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [8:0] d);
    return {s[30:0], s[31]} ^ {23'b0, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || bus_s.bram_ce !== 1'b0 || bus_s.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b ce=%b valid=%b want all 0", busy_s, done_s, bus_s.bram_ce, bus_s.out_valid);
    end
    checks++;
    if (bus_s.bram_bank !== 1'b0 || bus_s.bram_addr !== 2'd0 || sig_s !== 32'd0) begin
      errors++;
      $display("FAIL reset_ptr_sig: bank=%0d addr=%0d sig=%h want 0/0/0", bus_s.bram_bank, bus_s.bram_addr, sig_s);
    end
    checks++;
    if (busy_l !== 1'b0 || bus_l.out_valid !== 1'b0 || sig_l !== 32'd0) begin
      errors++;
      $display("FAIL reset_large: busy=%b valid=%b sig=%h want 0/0/0", busy_l, bus_l.out_valid, sig_l);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || bus_s.bram_ce !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ce=%b want 0/0", busy_s, bus_s.bram_ce);
    end
  endtask

  task automatic test_sweep_streaming();
    int n = 0, first_ce = -1, first_w = -1, last_w = -1, dones = 0;
    bus_s.out_ready = 1'b1;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (bus_s.bram_ce && first_ce < 0) first_ce = cyc;
      if (bus_s.out_valid && bus_s.out_ready) begin
        checks++;
        if (bus_s.out_data !== 9'(n) || bus_s.out_bank !== 1'(n / 4) || bus_s.out_addr !== 2'(n % 4)) begin
          errors++;
          $display("FAIL stream_word %0d: data=%0d bank=%0d addr=%0d want %0d/%0d/%0d",
                   n, bus_s.out_data, bus_s.out_bank, bus_s.out_addr, n, n / 4, n % 4);
        end
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
        n++;
      end
      if (done_s) begin
        dones++;
        checks++;
        if (busy_s !== 1'b0) begin errors++; $display("FAIL busy_in_done: busy=%b want 0", busy_s); end
      end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", n); end
    checks++;
    if (sig_s !== 32'h0000000F) begin errors++; $display("FAIL stream_sig: got %h want 0000000f", sig_s); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL stream_done: got %0d pulses want 1", dones); end
    checks++;
    if (busy_s !== 1'b0) begin errors++; $display("FAIL stream_busy_after: got %b want 0", busy_s); end
    checks++;
    if (first_ce != 1) begin errors++; $display("FAIL first_ce_cycle: got %0d want 1", first_ce); end
    checks++;
    if (last_w - first_w != 7) begin errors++; $display("FAIL throughput: span %0d want 7", last_w - first_w); end
  endtask

  task automatic test_backpressure();
    int ce_cnt = 0, n = 0, dones = 0;
    logic stable = 1'b1;
    bus_s.out_ready = 1'b0;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (bus_s.bram_ce) ce_cnt++;
      if (bus_s.out_valid && (bus_s.out_data !== 9'd0 || bus_s.out_bank !== 1'b0 || bus_s.out_addr !== 2'd0))
        stable = 1'b0;
    end
    checks++;
    if (ce_cnt != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", ce_cnt); end
    checks++;
    if (bus_s.bram_ce !== 1'b0 || bus_s.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: ce=%b valid=%b want 0/1", bus_s.bram_ce, bus_s.out_valid);
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_head_stable: got 0 want 1"); end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus_s.out_ready = 1'b1;
      if (bus_s.out_valid) begin
        checks++;
        if (bus_s.out_data !== 9'(n) || bus_s.out_bank !== 1'(n / 4) || bus_s.out_addr !== 2'(n % 4)) begin
          errors++;
          $display("FAIL bp_word %0d: data=%0d bank=%0d addr=%0d", n, bus_s.out_data, bus_s.out_bank, bus_s.out_addr);
        end
        n++;
      end
      if (done_s) dones++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", n); end
    checks++;
    if (sig_s !== 32'h0000000F) begin errors++; $display("FAIL bp_sig: got %h want 0000000f", sig_s); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", dones); end
  endtask

  task automatic test_start_ignored();
    int n = 0, dones = 0, ce_cnt = 0, busy_after = 0;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      start_s = (cyc == 5) || done_s;
      bus_s.out_ready = (cyc % 3 != 0);
      if (bus_s.bram_ce) ce_cnt++;
      if (dones > 0 && busy_s) busy_after++;
      if (done_s) dones++;
      if (bus_s.out_valid && bus_s.out_ready) begin
        checks++;
        if (bus_s.out_data !== 9'(n) || bus_s.out_bank !== 1'(n / 4) || bus_s.out_addr !== 2'(n % 4)) begin
          errors++;
          $display("FAIL restart_word %0d: data=%0d bank=%0d addr=%0d", n, bus_s.out_data, bus_s.out_bank, bus_s.out_addr);
        end
        n++;
      end
    end
    start_s = 1'b0;
    checks++;
    if (n != 8 || ce_cnt != 8) begin errors++; $display("FAIL restart_counts: words=%0d reads=%0d want 8/8", n, ce_cnt); end
    checks++;
    if (sig_s !== 32'h0000000F) begin errors++; $display("FAIL restart_sig: got %h want 0000000f", sig_s); end
    checks++;
    if (dones != 1 || busy_after != 0) begin
      errors++;
      $display("FAIL restart_done: pulses=%0d busy_after=%0d want 1/0", dones, busy_after);
    end
  endtask

  task automatic test_reset_abort();
    int ce_cnt = 0, n = 0, dones = 0, stale = 0;
    logic first_ok = 1'b1;
    logic seen_ce = 1'b0;
    bus_s.out_ready = 1'b0;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 20 && ce_cnt < 3; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (bus_s.bram_ce) ce_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || bus_s.bram_ce !== 1'b0 || bus_s.out_valid !== 1'b0 ||
        bus_s.bram_bank !== 1'b0 || bus_s.bram_addr !== 2'd0 || sig_s !== 32'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b ce=%b valid=%b bank=%0d addr=%0d sig=%h",
               busy_s, done_s, bus_s.bram_ce, bus_s.out_valid, bus_s.bram_bank, bus_s.bram_addr, sig_s);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done_s || bus_s.out_valid) stale++;
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done_s || bus_s.out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL abort_stale: got %0d cycles with valid/done want 0", stale); end
    bus_s.out_ready = 1'b1;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (bus_s.bram_ce && !seen_ce) begin
        seen_ce = 1'b1;
        if (bus_s.bram_bank !== 1'b0 || bus_s.bram_addr !== 2'd0) first_ok = 1'b0;
      end
      if (done_s) dones++;
      if (bus_s.out_valid && bus_s.out_ready) begin
        checks++;
        if (bus_s.out_data !== 9'(n) || bus_s.out_bank !== 1'(n / 4) || bus_s.out_addr !== 2'(n % 4)) begin
          errors++;
          $display("FAIL abort_word %0d: data=%0d bank=%0d addr=%0d", n, bus_s.out_data, bus_s.out_bank, bus_s.out_addr);
        end
        n++;
      end
    end
    checks++;
    if (!seen_ce || !first_ok) begin errors++; $display("FAIL abort_first_read: seen=%b at_origin=%b want 1/1", seen_ce, first_ok); end
    checks++;
    if (n != 8 || dones != 1 || sig_s !== 32'h0000000F) begin
      errors++;
      $display("FAIL abort_resweep: words=%0d dones=%0d sig=%h want 8/1/0000000f", n, dones, sig_s);
    end
  endtask

  task automatic test_random_large();
    int n = 0, dones = 0, done_cyc = 0, bad = 0;
    logic [31:0] exp_sig = 32'd0;
    for (int i = 0; i < 52 * 32; i++) mem_l[i] = 9'($urandom_range(0, 511));
    start_l = 1'b1;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      @(negedge clk);
      start_l = 1'b0;
      bus_l.out_ready = 1'($urandom_range(0, 1));
      if (bus_l.out_valid && bus_l.out_ready) begin
        if (n >= 52 * 32 || bus_l.out_data !== mem_l[n] || bus_l.out_bank !== 6'(n / 32) || bus_l.out_addr !== 5'(n % 32)) begin
          bad++;
          if (bad <= 5)
            $display("FAIL large_word %0d: data=%0d bank=%0d addr=%0d want bank %0d addr %0d",
                     n, bus_l.out_data, bus_l.out_bank, bus_l.out_addr, n / 32, n % 32);
        end else begin
          exp_sig = sig_step(exp_sig, mem_l[n]);
        end
        n++;
      end
      if (done_l) begin dones++; done_cyc = cyc; end
      if (dones > 0 && cyc >= done_cyc + 3) break;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL large_order: got %0d bad words want 0", bad); end
    checks++;
    if (n != 52 * 32) begin errors++; $display("FAIL large_count: got %0d want %0d", n, 52 * 32); end
    checks++;
    if (sig_l !== exp_sig) begin errors++; $display("FAIL large_sig: got %h want %h", sig_l, exp_sig); end
    checks++;
    if (dones != 1 || busy_l !== 1'b0) begin errors++; $display("FAIL large_done: pulses=%0d busy=%b want 1/0", dones, busy_l); end
  endtask

  initial begin
    start_s = 1'b0;
    start_l = 1'b0;
    bus_s.out_ready = 1'b0;
    bus_l.out_ready = 1'b0;
    test_reset();
    test_sweep_streaming();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    test_random_large();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
